// File: rtl/muldiv_sched_ctrl_if.sv
// Pipeline <-> MUL/DIV sequencer signal bundle: hazard inputs from EX/ID/WB, issue/write-port/enable outputs.
// master = the sequencer itself, slave = the surrounding pipeline and MUL/DIV unit.
interface muldiv_sched_ctrl_if;
  logic       EX_valid;
  logic       EX_md_op;
  logic       EX_is_div;
  logic [4:0] EX_rd_addr;
  logic       ext_hold;
  logic [4:0] ID_rs1_addr;
  logic [4:0] ID_rs2_addr;
  logic       ID_rd_rs2_en;
  logic [4:0] ID_rd_addr;
  logic       ID_rd_wren;
  logic       WB_rd_wren;
  logic       md_early_done;
  logic       md_start;
  logic       md_busy;
  logic       md_wb_sel;
  logic [4:0] md_wb_rd_addr;
  logic       pc_en;
  logic       IF_ID_en;
  logic       ID_EX_en;
  logic       EX_MEM_en;
  logic       MEM_WB_en;
  logic       ID_EX_rst_n;
  logic       EX_MEM_rst_n;

  modport master (
    input  EX_valid, EX_md_op, EX_is_div, EX_rd_addr, ext_hold,
    input  ID_rs1_addr, ID_rs2_addr, ID_rd_rs2_en, ID_rd_addr, ID_rd_wren,
    input  WB_rd_wren, md_early_done,
    output md_start, md_busy, md_wb_sel, md_wb_rd_addr,
    output pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
    output ID_EX_rst_n, EX_MEM_rst_n
  );

  modport slave (
    output EX_valid, EX_md_op, EX_is_div, EX_rd_addr, ext_hold,
    output ID_rs1_addr, ID_rs2_addr, ID_rd_rs2_en, ID_rd_addr, ID_rd_wren,
    output WB_rd_wren, md_early_done,
    input  md_start, md_busy, md_wb_sel, md_wb_rd_addr,
    input  pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
    input  ID_EX_rst_n, EX_MEM_rst_n
  );
endinterface

// File: rtl/muldiv_sched_ctrl.sv
// MUL/DIV sequencer: issue -> result write after MUL_LAT/DIV_LAT cycles; stalls the pipeline for structural, RAW/WAW and WB-port hazards.
// Optional `MD_EARLY_OUT_EN lets md_early_done end BUSY early; enables/outputs are forced benign while rst_n is low.
module muldiv_sched_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33
) (
  input logic                clk,
  input logic                rst_n,
  muldiv_sched_ctrl_if.master md
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [7:0] MUL_CNT = 8'(MUL_LAT - 1);
  localparam logic [7:0] DIV_CNT = 8'(DIV_LAT - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] cnt, cnt_nxt, issue_cnt;
  logic [4:0] pend_rd, pend_rd_nxt, haz_rd;
  logic       ex_md, issue, early, wb_sel_raw, wb_collide, struct_haz, rd_haz;

  assign ex_md     = md.EX_valid & md.EX_md_op;
  assign issue     = (state == IDLE) & ex_md & ~md.ext_hold;
  assign issue_cnt = md.EX_is_div ? DIV_CNT : MUL_CNT;

`ifdef MD_EARLY_OUT_EN
  assign early = md.md_early_done;
`else
  logic unused_early_done;
  assign unused_early_done = md.md_early_done;
  assign early = 1'b0;
`endif

  // cnt hits 0 in the WRITE cycle itself, so BUSY hands over when cnt is 1.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_rd_nxt = pend_rd;
    case (state)
      IDLE: begin
        if (issue) begin
          pend_rd_nxt = md.EX_rd_addr;
          cnt_nxt     = issue_cnt;
          state_nxt   = (issue_cnt == 8'd0) ? WRITE : BUSY;
        end
      end
      BUSY: begin
        if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
        if ((cnt <= 8'd1) || early) state_nxt = WRITE;
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      pend_rd <= 5'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_rd <= pend_rd_nxt;
    end
  end

  assign wb_sel_raw = (state == WRITE) & (pend_rd != 5'd0);
  assign wb_collide = wb_sel_raw & md.WB_rd_wren;
  assign struct_haz = ex_md & (state != IDLE);
  // In IDLE the op sitting in EX is about to become the pending write.
  assign haz_rd     = (state != IDLE) ? pend_rd : (ex_md ? md.EX_rd_addr : 5'd0);
  assign rd_haz     = (haz_rd != 5'd0) &
                      ((md.ID_rs1_addr == haz_rd) |
                       ((md.ID_rs2_addr == haz_rd) & ~md.ID_rd_rs2_en) |
                       (md.ID_rd_wren & (md.ID_rd_addr == haz_rd)));

  always_comb begin
    md.md_start      = 1'b0;
    md.md_busy       = 1'b0;
    md.md_wb_sel     = 1'b0;
    md.md_wb_rd_addr = 5'd0;
    md.pc_en         = 1'b1;
    md.IF_ID_en      = 1'b1;
    md.ID_EX_en      = 1'b1;
    md.EX_MEM_en     = 1'b1;
    md.MEM_WB_en     = 1'b1;
    md.ID_EX_rst_n   = 1'b1;
    md.EX_MEM_rst_n  = 1'b1;
    if (rst_n) begin
      md.md_start      = issue;
      md.md_busy       = (state != IDLE);
      md.md_wb_sel     = wb_sel_raw;
      md.md_wb_rd_addr = (state == WRITE) ? pend_rd : 5'd0;
      if (wb_collide) begin
        md.pc_en     = 1'b0;
        md.IF_ID_en  = 1'b0;
        md.ID_EX_en  = 1'b0;
        md.EX_MEM_en = 1'b0;
        md.MEM_WB_en = 1'b0;
      end else if (struct_haz) begin
        md.pc_en        = 1'b0;
        md.IF_ID_en     = 1'b0;
        md.ID_EX_en     = 1'b0;
        md.EX_MEM_rst_n = 1'b0;
      end else if (rd_haz) begin
        md.pc_en       = 1'b0;
        md.IF_ID_en    = 1'b0;
        md.ID_EX_rst_n = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sched_ctrl.sv
// Bench for muldiv_sched_ctrl: table of single-cycle hazard vectors from IDLE, then multi-cycle sequences
// whose MUL/DIV writes are predicted into a scoreboard queue and matched against md_wb_sel.
module tb_muldiv_sched_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_sched_ctrl_if mif();
  muldiv_sched_ctrl #(.MUL_LAT(4), .DIV_LAT(33)) dut (.clk(clk), .rst_n(rst_n), .md(mif));

`ifdef MD_EARLY_OUT_EN
  localparam int EARLY_W = 4;
`else
  localparam int EARLY_W = 33;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0] rd;
    int         wcyc;
  } wb_exp_t;
  wb_exp_t sb_q[$];

  typedef struct {
    string      name;
    logic       rst;
    logic       ex_v, ex_md, hold;
    logic [4:0] ex_rd, rs1, rs2;
    logic       imm;
    logic [4:0] id_rd;
    logic       id_wr;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // {md_start, pc, IF_ID, ID_EX, EX_MEM, MEM_WB enables, ID_EX_rst_n, EX_MEM_rst_n}
  function automatic logic [7:0] outs();
    return {mif.md_start, mif.pc_en, mif.IF_ID_en, mif.ID_EX_en, mif.EX_MEM_en,
            mif.MEM_WB_en, mif.ID_EX_rst_n, mif.EX_MEM_rst_n};
  endfunction

  always @(negedge clk) begin
    wb_exp_t e;
    if (mif.md_wb_sel === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected cyc=%0d actual_rd=%0d required=no write", cyc, mif.md_wb_rd_addr);
      end else begin
        e = sb_q.pop_front();
        if ((cyc != e.wcyc) || (mif.md_wb_rd_addr !== e.rd)) begin
          failures++;
          $display("FAIL wb_match actual cyc=%0d rd=%0d required cyc=%0d rd=%0d",
                   cyc, mif.md_wb_rd_addr, e.wcyc, e.rd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mif.EX_valid = 0; mif.EX_md_op = 0; mif.EX_is_div = 0; mif.EX_rd_addr = 0;
    mif.ext_hold = 0; mif.ID_rs1_addr = 0; mif.ID_rs2_addr = 0; mif.ID_rd_rs2_en = 0;
    mif.ID_rd_addr = 0; mif.ID_rd_wren = 0; mif.WB_rd_wren = 0; mif.md_early_done = 0;
  endtask

  task automatic drive_ex(input logic [4:0] rd, input logic is_div);
    mif.EX_valid = 1; mif.EX_md_op = 1; mif.EX_is_div = is_div; mif.EX_rd_addr = rd;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input int c);
    wb_exp_t e;
    e.rd = rd;
    e.wcyc = c;
    sb_q.push_back(e);
  endtask

  task automatic add(input string n, input logic r, input logic v, input logic m, input logic h,
                     input logic [4:0] er, input logic [4:0] s1, input logic [4:0] s2, input logic im,
                     input logic [4:0] ir, input logic iw, input logic [7:0] x);
    vec_t t;
    t.name = n; t.rst = r; t.ex_v = v; t.ex_md = m; t.hold = h; t.ex_rd = er;
    t.rs1 = s1; t.rs2 = s2; t.imm = im; t.id_rd = ir; t.id_wr = iw; t.exp = x;
    vecs.push_back(t);
  endtask

  initial begin
    //   name            rst v  md hold exrd rs1 rs2 imm idrd wr  expected
    add("reset_forced",  0, 1, 1, 0,   5,   5,  5,  0,  5,   1, 8'h7F);
    add("idle_quiet",    1, 0, 0, 0,   0,   0,  0,  0,  0,   0, 8'h7F);
    add("issue_mul",     1, 1, 1, 0,   5,   1,  2,  0,  3,   1, 8'hFF);
    add("issue_held",    1, 1, 1, 1,   5,   1,  2,  0,  3,   1, 8'h7F);
    add("raw_rs1",       1, 1, 1, 0,   5,   5,  2,  0,  3,   1, 8'h9D);
    add("raw_rs2",       1, 1, 1, 0,   5,   1,  5,  0,  3,   0, 8'h9D);
    add("rs2_imm",       1, 1, 1, 0,   5,   1,  5,  1,  3,   1, 8'hFF);
    add("waw",           1, 1, 1, 0,   5,   1,  2,  0,  5,   1, 8'h9D);
    add("rd_no_wren",    1, 1, 1, 0,   5,   1,  2,  0,  5,   0, 8'hFF);
    add("x0_dest",       1, 1, 1, 0,   0,   0,  0,  0,  0,   1, 8'hFF);
    add("ex_invalid",    1, 0, 1, 0,   5,   5,  5,  0,  5,   1, 8'h7F);
    add("not_md",        1, 1, 0, 0,   5,   5,  5,  0,  5,   1, 8'h7F);
    add("hold_raw",      1, 1, 1, 1,   5,   5,  2,  0,  3,   0, 8'h1D);

    rst_n = 0;
    clear_in();
    tick();
    tick();
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst;
      mif.EX_valid = vecs[i].ex_v; mif.EX_md_op = vecs[i].ex_md; mif.ext_hold = vecs[i].hold;
      mif.EX_rd_addr = vecs[i].ex_rd; mif.ID_rs1_addr = vecs[i].rs1; mif.ID_rs2_addr = vecs[i].rs2;
      mif.ID_rd_rs2_en = vecs[i].imm; mif.ID_rd_addr = vecs[i].id_rd; mif.ID_rd_wren = vecs[i].id_wr;
      @(negedge clk);
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      check({vecs[i].name, "_busy"}, 32'(mif.md_busy), 32'd0);
      rst_n = 0;
      clear_in();
      tick();
    end

    // MUL x5, no other traffic
    rst_n = 1;
    t0 = cyc;
    drive_ex(5, 0);
    expect_wb(5, t0 + 4);
    @(negedge clk);
    check("mul_start", 32'(mif.md_start), 32'd1);
    tick();
    clear_in();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("mul_busy", 32'(mif.md_busy), 32'd1);
      check("mul_no_restart", 32'(mif.md_start), 32'd0);
      if (k == 4) check("mul_write_enables", 32'(outs()), 32'h7F);
      tick();
    end
    @(negedge clk);
    check("mul_idle", 32'(mif.md_busy), 32'd0);
    tick();

    // DIV x7 then ADD x8,x7,x1 waiting in ID
    t0 = cyc;
    drive_ex(7, 1);
    mif.ID_rs1_addr = 7; mif.ID_rs2_addr = 1; mif.ID_rd_addr = 8; mif.ID_rd_wren = 1;
    expect_wb(7, t0 + 33);
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (k <= 33) check("div_raw_stall", 32'({mif.pc_en, mif.ID_EX_rst_n}), 32'd0);
      else         check("div_raw_release", 32'({mif.pc_en, mif.ID_EX_rst_n}), 32'd3);
      tick();
      mif.EX_valid = 0;
      mif.EX_md_op = 0;
    end
    clear_in();

    // MUL x3 whose write collides with a pipeline WB write
    t0 = cyc;
    drive_ex(3, 0);
    expect_wb(3, t0 + 4);
    for (int k = 0; k < 4; k++) begin
      tick();
      clear_in();
    end
    mif.WB_rd_wren = 1;
    @(negedge clk);
    check("wb_collide_enables", 32'(outs()), 32'h03);
    tick();
    @(negedge clk);
    check("wb_retry_enables", 32'(outs()), 32'h7F);
    check("wb_retry_no_md", 32'(mif.md_wb_sel), 32'd0);
    tick();
    clear_in();

    // Back-to-back MUL x10, MUL x11
    t0 = cyc;
    drive_ex(10, 0);
    expect_wb(10, t0 + 4);
    @(negedge clk);
    check("b2b_first_start", 32'(mif.md_start), 32'd1);
    tick();
    drive_ex(11, 0);
    expect_wb(11, t0 + 9);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("b2b_struct_stall", 32'(outs()), 32'h0E);
      tick();
    end
    @(negedge clk);
    check("b2b_second_start", 32'(outs()), 32'hFF);
    tick();
    clear_in();
    repeat (5) tick();

    // Reset in the middle of a DIV
    t0 = cyc;
    drive_ex(12, 1);
    @(negedge clk);
    check("rst_div_start", 32'(mif.md_start), 32'd1);
    tick();
    clear_in();
    tick();
    rst_n = 0;
    @(negedge clk);
    check("rst_forced_enables", 32'(outs()), 32'h7F);
    check("rst_forced_busy", 32'(mif.md_busy), 32'd0);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("rst_idle_busy", 32'(mif.md_busy), 32'd0);
    check("rst_idle_enables", 32'(outs()), 32'h7F);
    repeat (40) tick();

    // x0 destination: sequenced but never written, never a hazard
    drive_ex(0, 0);
    mif.ID_rs1_addr = 0;
    mif.ID_rd_wren = 1;
    tick();
    mif.EX_valid = 0;
    mif.EX_md_op = 0;
    tick();
    tick();
    tick();
    @(negedge clk);
    check("x0_busy_in_write", 32'(mif.md_busy), 32'd1);
    check("x0_no_wb_sel", 32'(mif.md_wb_sel), 32'd0);
    check("x0_no_hazard", 32'(outs()), 32'h7F);
    tick();
    clear_in();
    tick();

    // DIV x9 with early-done pulse in cycle 3
    t0 = cyc;
    drive_ex(9, 1);
    expect_wb(9, t0 + EARLY_W);
    tick();
    clear_in();
    tick();
    tick();
    mif.md_early_done = 1;
    tick();
    mif.md_early_done = 0;
    repeat (33) tick();

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
